// File: rtl/sdram_issuer_pkg.sv
// rtl/sdram_issuer_pkg.sv - command encodings and FSM states for the SDRAM command issuer
package sdram_issuer_pkg;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// rtl/sdram_addr_gen.sv - per-port wrapping burst address with deferred reload
module sdram_addr_gen #(
  parameter int               ASIZE = 23,
  parameter int               BURST = 8,
  parameter logic [ASIZE-1:0] BASE  = '0,
  parameter logic [ASIZE-1:0] MAX   = 23'h100000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic             BUSY,
  input  logic             ADVANCE,
  output logic [ASIZE-1:0] ADDR
);

  logic             pending;
  logic [ASIZE:0]   next_sum;
  logic [ASIZE-1:0] next_addr;

  // One extra bit so an address near the top cannot overflow past MAX unnoticed
  assign next_sum  = {1'b0, ADDR} + (ASIZE+1)'(BURST);
  assign next_addr = (next_sum >= {1'b0, MAX}) ? BASE : next_sum[ASIZE-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ADDR    <= BASE;
      pending <= 1'b0;
    end else if (ADVANCE) begin
      ADDR    <= (pending || LOAD) ? BASE : next_addr;
      pending <= 1'b0;
    end else if (LOAD) begin
      if (BUSY)
        pending <= 1'b1;
      else
        ADDR <= BASE;
    end
  end

endmodule

// File: rtl/sdram_cmd_issuer.sv
// rtl/sdram_cmd_issuer.sv - arbitrates write/read FIFOs and issues READA/WRITEA bursts
module sdram_cmd_issuer
  import sdram_issuer_pkg::*;
#(
  parameter int               ASIZE     = 23,
  parameter int               BURST     = 8,
  parameter int               FIFO_AW   = 9,
  parameter int               DONE_WAIT = 12,
  parameter logic [ASIZE-1:0] WR_BASE   = '0,
  parameter logic [ASIZE-1:0] WR_MAX    = 23'h100000,
  parameter logic [ASIZE-1:0] RD_BASE   = '0,
  parameter logic [ASIZE-1:0] RD_MAX    = 23'h100000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               INIT_DONE,
  input  logic [FIFO_AW-1:0] WR_USED,
  input  logic [FIFO_AW-1:0] RD_USED,
  input  logic               WR_LOAD,
  input  logic               RD_LOAD,
  input  logic               CMD_ACK,
  output logic [2:0]         CMD,
  output logic [ASIZE-1:0]   ADDR,
  output logic               WR_SEL,
  output logic               BUSY,
  output logic               WR_DONE,
  output logic               RD_DONE
);

  localparam int               CNT_W   = $clog2(DONE_WAIT + 1);
  localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] BURST_W = (FIFO_AW+1)'(BURST);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_wr;
  logic [ASIZE-1:0] wr_addr, rd_addr;
  logic [FIFO_AW:0] rd_free;
  logic             wr_ok, rd_ok, grant_wr, done;

  assign rd_free  = DEPTH - {1'b0, RD_USED};
  assign wr_ok    = INIT_DONE && ({1'b0, WR_USED} >= BURST_W);
  assign rd_ok    = INIT_DONE && (rd_free >= BURST_W);
  // On a tie serve the port that did not go last
  assign grant_wr = wr_ok && (!rd_ok || !last_wr);
  assign done     = (state == WAIT) && (cnt == '0);

  sdram_addr_gen #(.ASIZE(ASIZE), .BURST(BURST), .BASE(WR_BASE), .MAX(WR_MAX)) u_wr_addr (
    .CLK     (CLK),
    .RESET   (RESET),
    .LOAD    (WR_LOAD),
    .BUSY    ((state != IDLE) && WR_SEL),
    .ADVANCE (done && WR_SEL),
    .ADDR    (wr_addr)
  );

  sdram_addr_gen #(.ASIZE(ASIZE), .BURST(BURST), .BASE(RD_BASE), .MAX(RD_MAX)) u_rd_addr (
    .CLK     (CLK),
    .RESET   (RESET),
    .LOAD    (RD_LOAD),
    .BUSY    ((state != IDLE) && !WR_SEL),
    .ADVANCE (done && !WR_SEL),
    .ADDR    (rd_addr)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      CMD     <= CMD_NOP;
      ADDR    <= '0;
      WR_SEL  <= 1'b0;
      BUSY    <= 1'b0;
      WR_DONE <= 1'b0;
      RD_DONE <= 1'b0;
      cnt     <= '0;
      last_wr <= 1'b0;
    end else begin
      WR_DONE <= 1'b0;
      RD_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok || rd_ok) begin
            state  <= ISSUE;
            BUSY   <= 1'b1;
            WR_SEL <= grant_wr;
            CMD    <= grant_wr ? CMD_WRITEA : CMD_READA;
            ADDR   <= grant_wr ? wr_addr : rd_addr;
          end
        end
        ISSUE: begin
          if (CMD_ACK) begin
            CMD   <= CMD_NOP;
            cnt   <= CNT_W'(DONE_WAIT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            WR_DONE <= WR_SEL;
            RD_DONE <= !WR_SEL;
            BUSY    <= 1'b0;
            last_wr <= WR_SEL;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
